// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the 16-lane TDM demultiplexer.
// Lane count, slot index width, FSM state encoding, last slot index.
package tdm_demux_pkg;

  localparam int LANES = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } tdm_state_t;

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(LANES - 1);

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: sync clear, load-to-1, enable; flags LAST_SLOT.
// Ports: clk, rst_n, clr_i, load1_i, en_i -> cnt_o, last_o.
module tdm_slot_counter
  import tdm_demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load1_i,
  input  logic             en_i,
  output logic [SEL_W-1:0] cnt_o,
  output logic             last_o
);

  logic [SEL_W-1:0] cnt_q;
  logic [SEL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load1_i) begin
      cnt_d = SEL_W'(1);
    end else if (en_i) begin
      cnt_d = cnt_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LAST_SLOT);

endmodule

// File: rtl/tdm_demux16.sv
// Serial-to-parallel 16-slot TDM demultiplexer with frame-start sync.
// Ports: clk, rst_n, din, din_valid, frame_start -> y, frame_valid, frame_err, sel, busy.
module tdm_demux16
  import tdm_demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [LANES-1:0] y,
  output logic             frame_valid,
  output logic             frame_err,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  tdm_state_t       state_q;
  // Slot 15 goes straight into y, so the shadow only keeps slots 0..14.
  logic [LANES-2:0] shadow_q;
  logic [LANES-1:0] y_q;
  logic             fv_q;
  logic             fe_q;
  logic             busy_q;

  logic [SEL_W-1:0] sel_cnt;
  logic             last;
  logic             start_idle;
  logic             restart;
  logic             take;
  logic             done;

  always_comb begin
    start_idle = (state_q == IDLE) && din_valid && frame_start;
    restart    = (state_q == CAPTURE) && din_valid && frame_start;
    take       = (state_q == CAPTURE) && din_valid && !frame_start;
    done       = take && last;
  end

  tdm_slot_counter u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (done),
    .load1_i (start_idle || restart),
    .en_i    (take && !last),
    .cnt_o   (sel_cnt),
    .last_o  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      fe_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      fv_q <= 1'b0;
      fe_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_idle) begin
            shadow_q[0] <= din;
            state_q     <= CAPTURE;
            busy_q      <= 1'b1;
          end
        end
        CAPTURE: begin
          if (restart) begin
            // Partial frame is dropped; this bit is the new slot 0.
            fe_q        <= 1'b1;
            shadow_q[0] <= din;
          end else if (take) begin
            if (last) begin
              y_q     <= {din, shadow_q};
              fv_q    <= 1'b1;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              shadow_q[sel_cnt] <= din;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign y           = y_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign sel         = sel_cnt;
  assign busy        = busy_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// Scoreboard bench for tdm_demux16 with a slot-list reference model.
// Drives directed scenarios plus random serial traffic.
module tb_tdm_demux16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [15:0] y;
  logic        frame_valid;
  logic        frame_err;
  logic [3:0]  sel;
  logic        busy;

  tdm_demux16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_start (frame_start),
    .y           (y),
    .frame_valid (frame_valid),
    .frame_err   (frame_err),
    .sel         (sel),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    logic [15:0] y;
    int          cyc;
  } ev_t;

  ev_t  evq[$];
  bit   bits[$];
  bit   in_frame = 0;
  logic [15:0] m_y = '0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  function automatic logic [15:0] mux_word(input bit q[$]);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < q.size(); i++) w[i] = q[i];
    return w;
  endfunction

  // Reference model: a frame is just an ordered list of received bits.
  task automatic model_edge();
    ev_t e;
    if (!rst_n) begin
      bits.delete();
      in_frame = 0;
      m_y = '0;
    end else if (din_valid) begin
      if (frame_start) begin
        if (in_frame) begin
          e.err = 1; e.y = m_y; e.cyc = cyc;
          evq.push_back(e);
        end
        bits.delete();
        bits.push_back(din);
        in_frame = 1;
      end else if (in_frame) begin
        bits.push_back(din);
        if (bits.size() == 16) begin
          m_y = mux_word(bits);
          e.err = 0; e.y = m_y; e.cyc = cyc;
          evq.push_back(e);
          bits.delete();
          in_frame = 0;
        end
      end
    end
  endtask

  task automatic step(input logic v, input logic d,
                      input logic fs, input logic rn = 1'b1);
    din_valid = v;
    din = d;
    frame_start = fs;
    rst_n = rn;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_slots(input logic [15:0] w, input int n,
                            input logic [15:0] gmask, input int glen);
    for (int s = 0; s < n; s++) begin
      step(1'b1, w[s], s == 0);
      if (gmask[s]) gap(glen);
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      check("y", 32'(y), 32'(m_y));
      check("sel", 32'(sel), in_frame ? 32'(bits.size()) : 32'd0);
      check("busy", 32'(busy), 32'(in_frame));
      if (frame_valid && frame_err)
        check("valid_err_overlap", 32'd1, 32'd0);
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        e = evq.pop_front();
        check(e.err ? "missing_frame_err" : "missing_frame_valid",
              32'd0, 32'd1);
      end
      if (frame_valid || frame_err) begin
        if (evq.size() > 0 && evq[0].cyc == cyc) begin
          e = evq.pop_front();
          check("event_kind", 32'(frame_err), 32'(e.err));
          if (!e.err) check("frame_y", 32'(y), 32'(e.y));
        end else begin
          check(frame_err ? "unexpected_frame_err"
                          : "unexpected_frame_valid", 32'd1, 32'd0);
        end
      end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        check(e.err ? "missing_frame_err" : "missing_frame_valid",
              32'd0, 32'd1);
      end
    end
  end

  initial begin
    logic [15:0] w;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    mon_en = 1;
    @(negedge clk); #1;
    check("reset_fv", 32'(frame_valid), 32'd0);
    check("reset_fe", 32'(frame_err), 32'd0);

    // Pre-sync noise
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0);
    // Loopback 16'h1248
    send_slots(16'h1248, 16, 16'h0000, 0);
    gap(2);
    // Gapped frame
    send_slots(16'h1248, 16, 16'h0810, 3);
    gap(2);
    // Early restart at slot 7 then A5A5
    send_slots(16'h5A3C, 7, 16'h0000, 0);
    send_slots(16'hA5A5, 16, 16'h0000, 0);
    gap(1);
    // Back-to-back
    send_slots(16'hFFFF, 16, 16'h0000, 0);
    send_slots(16'h0001, 16, 16'h0000, 0);
    gap(2);
    // Reset mid-frame after y = 16'h1248
    send_slots(16'h1248, 16, 16'h0000, 0);
    send_slots(16'hC3C3, 9, 16'h0000, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    send_slots(16'h6E91, 16, 16'h0000, 0);
    gap(2);

    // Random full frames with random gaps
    for (int f = 0; f < 12; f++) begin
      w = 16'($urandom);
      send_slots(w, 16, 16'($urandom) & 16'h7FFF, $urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) gap($urandom_range(0, 3));
    end
    // Random unconstrained traffic
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 9) < 7), 1'($urandom),
           ($urandom_range(0, 14) == 0));
    gap(3);

    check("events_drained", 32'(evq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
